// File: rtl/adder_2_sweep_eval.sv
// Exhaustive 128-vector error evaluator for the 7-in/4-out approximate adder.
// Optional worst-vector capture: define SWEEP_EVAL_WCE_CAPTURE_EN.
module adder_2_sweep_eval #(
   parameter int unsigned SETTLE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic [6:0]  vec_o,
   input  logic [3:0]  approx_i,
   output logic        busy,
   output logic        done,
   output logic [7:0]  err_count,
   output logic [3:0]  max_ed,
   output logic [10:0] sum_ed,
   output logic [6:0]  worst_vec
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   // Reference sum: operand bits are interleaved across the adder pins.
   function automatic logic [3:0] exact_sum(input logic [6:0] v);
      logic [3:0] a;
      logic [3:0] b;
      a = {1'b0, v[1], v[2], v[0]};
      b = {1'b0, v[4], v[5], v[3]};
      return a + b + {3'b000, v[6]};
   endfunction

   function automatic logic [3:0] err_dist(input logic [3:0] ex, input logic [3:0] ap);
      logic signed [4:0] d;
      d = $signed({1'b0, ex}) - $signed({1'b0, ap});
      return d[4] ? 4'(-d) : d[3:0];
   endfunction

   state_t      r_state, w_state_nxt;
   logic [6:0]  r_vec, w_vec_nxt;
   logic [3:0]  r_wait, w_wait_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_done, w_done_nxt;
   logic [7:0]  r_err_cnt, w_err_cnt_nxt;
   logic [3:0]  r_max_ed, w_max_ed_nxt;
   logic [10:0] r_sum_ed, w_sum_ed_nxt;
   logic [3:0]  w_exact;
   logic [3:0]  w_ed;
`ifdef SWEEP_EVAL_WCE_CAPTURE_EN
   logic [6:0]  r_worst, w_worst_nxt;
`endif

   assign w_exact = exact_sum(r_vec);
   assign w_ed    = err_dist(w_exact, approx_i);

   // Next-state, sweep control and accumulator update.
   always_comb begin
      w_state_nxt   = r_state;
      w_vec_nxt     = r_vec;
      w_wait_nxt    = r_wait;
      w_done_nxt    = 1'b0;
      w_err_cnt_nxt = r_err_cnt;
      w_max_ed_nxt  = r_max_ed;
      w_sum_ed_nxt  = r_sum_ed;
`ifdef SWEEP_EVAL_WCE_CAPTURE_EN
      w_worst_nxt   = r_worst;
`endif
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt   = S_DRIVE;
               w_vec_nxt     = 7'd0;
               w_wait_nxt    = SETTLE_C;
               w_err_cnt_nxt = 8'd0;
               w_max_ed_nxt  = 4'd0;
               w_sum_ed_nxt  = 11'd0;
`ifdef SWEEP_EVAL_WCE_CAPTURE_EN
               w_worst_nxt   = 7'd0;
`endif
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_DRIVE: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_vec_nxt   = 7'd0;
            end else if (r_wait == 4'd0) begin
               w_state_nxt = S_SAMPLE;
            end else begin
               w_wait_nxt = r_wait - 4'd1;
            end
         end
         S_SAMPLE: begin
            // Abort discards this cycle's sample entirely.
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_vec_nxt   = 7'd0;
            end else begin
               w_err_cnt_nxt = r_err_cnt + {7'd0, (w_ed != 4'd0)};
               w_sum_ed_nxt  = r_sum_ed + {7'd0, w_ed};
               if (w_ed > r_max_ed) begin
                  w_max_ed_nxt = w_ed;
`ifdef SWEEP_EVAL_WCE_CAPTURE_EN
                  w_worst_nxt  = r_vec;
`endif
               end else begin
                  w_max_ed_nxt = r_max_ed;
               end
               if (r_vec == 7'd127) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_DRIVE;
                  w_vec_nxt   = r_vec + 7'd1;
                  w_wait_nxt  = SETTLE_C;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_vec_nxt   = 7'd0;
         end
      endcase
      w_busy_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_SAMPLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_vec     <= 7'd0;
         r_wait    <= 4'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err_cnt <= 8'd0;
         r_max_ed  <= 4'd0;
         r_sum_ed  <= 11'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_vec     <= w_vec_nxt;
         r_wait    <= w_wait_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err_cnt <= w_err_cnt_nxt;
         r_max_ed  <= w_max_ed_nxt;
         r_sum_ed  <= w_sum_ed_nxt;
      end
   end

`ifdef SWEEP_EVAL_WCE_CAPTURE_EN
   // First vector that reached the current worst error distance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_worst <= 7'd0;
      end else begin
         r_worst <= w_worst_nxt;
      end
   end
   assign worst_vec = r_worst;
`else
   assign worst_vec = 7'd0;
`endif

   assign vec_o     = r_vec;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err_count = r_err_cnt;
   assign max_ed    = r_max_ed;
   assign sum_ed    = r_sum_ed;

endmodule

// File: tb/tb_adder_2_sweep_eval.sv
// Self-checking bench: table-driven adder stand-in plus a per-vector arithmetic model.
module tb_adder_2_sweep_eval;
   localparam int S = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [6:0]  vec_o;
   logic [3:0]  approx_i;
   logic        busy, done;
   logic [7:0]  err_count;
   logic [3:0]  max_ed;
   logic [10:0] sum_ed;
   logic [6:0]  worst_vec;

   logic [3:0]  approx_tab [128];
   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   adder_2_sweep_eval #(.SETTLE(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .vec_o(vec_o), .approx_i(approx_i), .busy(busy), .done(done),
      .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed), .worst_vec(worst_vec)
   );

   always #5 clk = ~clk;
   always_comb approx_i = approx_tab[vec_o];
   always @(negedge clk) if (done) done_seen++;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exact_of(input int v);
      int a, b;
      a = ((v >> 1) & 1) * 4 + ((v >> 2) & 1) * 2 + (v & 1);
      b = ((v >> 4) & 1) * 4 + ((v >> 5) & 1) * 2 + ((v >> 3) & 1);
      return a + b + ((v >> 6) & 1);
   endfunction

   task automatic model(input int n, output int e_cnt, output int e_max,
                        output int e_sum, output int e_worst);
      int ed;
      e_cnt = 0; e_max = 0; e_sum = 0; e_worst = 0;
      for (int v = 0; v < n; v++) begin
         ed = exact_of(v) - int'(approx_tab[v]);
         if (ed < 0) ed = -ed;
         if (ed != 0) e_cnt++;
         e_sum += ed;
         if (ed > e_max) begin
            e_max = ed;
            e_worst = v;
         end
      end
`ifndef SWEEP_EVAL_WCE_CAPTURE_EN
      e_worst = 0;
`endif
   endtask

   task automatic run_sweep(input string tag, input bit with_abort);
      int c, prev, order_err, seen, d0;
      int e_cnt, e_max, e_sum, e_worst;
      model(128, e_cnt, e_max, e_sum, e_worst);
      d0 = done_seen;
      @(negedge clk); start = 1'b1; abort = with_abort;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      chk({tag, "_busy_rise"}, busy, 1);
      chk({tag, "_vec0"}, vec_o, 0);
      chk({tag, "_clr_cnt"}, err_count, 0);
      chk({tag, "_clr_sum"}, sum_ed, 0);
      chk({tag, "_clr_max"}, max_ed, 0);
      c = 0; prev = 0; seen = 1; order_err = 0;
      while (c < 20000) begin
         @(negedge clk);
         c++;
         start = (c == 3);
         if (done) break;
         if (int'(vec_o) != prev) begin
            if (int'(vec_o) != prev + 1) order_err++;
            prev = int'(vec_o);
            seen++;
         end
      end
      start = 1'b0;
      chk({tag, "_length"}, c, 128 * (S + 2));
      chk({tag, "_busy_fall"}, busy, 0);
      chk({tag, "_order"}, order_err, 0);
      chk({tag, "_seen"}, seen, 128);
      chk({tag, "_err_count"}, err_count, e_cnt);
      chk({tag, "_max_ed"}, max_ed, e_max);
      chk({tag, "_sum_ed"}, sum_ed, e_sum);
      chk({tag, "_worst"}, worst_vec, e_worst);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_done_count"}, done_seen - d0, 1);
      chk({tag, "_hold_vec"}, vec_o, 127);
      chk({tag, "_hold_sum"}, sum_ed, e_sum);
   endtask

   initial begin
      int e_cnt, e_max, e_sum, e_worst, c, d0;
      for (int v = 0; v < 128; v++) approx_tab[v] = 4'(exact_of(v));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_vec", vec_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", err_count, 0);
      chk("rst_max", max_ed, 0);
      chk("rst_sum", sum_ed, 0);
      chk("rst_worst", worst_vec, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_sweep("exact", 1'b0);

      for (int v = 0; v < 128; v++) approx_tab[v] = 4'd0;
      run_sweep("stuck0", 1'b0);

      for (int v = 0; v < 128; v++) approx_tab[v] = 4'(exact_of(v) ^ 1);
      run_sweep("xor1", 1'b0);

      // Abort in the SAMPLE cycle of vector 10 with a stuck-at-0 adder.
      for (int v = 0; v < 128; v++) approx_tab[v] = 4'd0;
      d0 = done_seen;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 0;
      while (vec_o != 7'd10 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      chk("abort_reach10", vec_o, 10);
      repeat (S + 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      model(10, e_cnt, e_max, e_sum, e_worst);
      chk("abort_busy", busy, 0);
      chk("abort_vec", vec_o, 0);
      chk("abort_cnt", err_count, e_cnt);
      chk("abort_sum", sum_ed, e_sum);
      chk("abort_max", max_ed, e_max);
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_seen - d0, 0);
      chk("abort_idle_vec", vec_o, 0);
      run_sweep("rescan", 1'b0);

      for (int v = 0; v < 128; v++) approx_tab[v] = 4'($urandom_range(0, 15));
      run_sweep("rand_lut", 1'b1);

      // Asynchronous reset mid-sweep.
      for (int v = 0; v < 128; v++)
         approx_tab[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(exact_of(v));
      d0 = done_seen;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (50 + $urandom_range(0, 20)) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_vec", vec_o, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cnt", err_count, 0);
      chk("mid_rst_sum", sum_ed, 0);
      chk("mid_rst_max", max_ed, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_no_done", done_seen - d0, 0);
      run_sweep("post_rst", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
